apb_rx_fifo: RTL
================

Name: apb_rx_fifo

Overview:
Receive buffer sitting directly downstream of the UART APB RX path. Accepts one completed frame per push strobe from the RX datapath and validates start/stop bits in 10-bit mode. Stores data byte plus frame-error flag in a circular FIFO and presents it to the APB read side through a pop handshake. Provides level, overflow and threshold-interrupt status for the APB register block.

Parameters:
DEPTH, 16, number of FIFO entries; power of two, minimum 4.
AW, 4, pointer width; log2(DEPTH).
THRESH, 8, fill level at or above which thresh_irq asserts; range 1..DEPTH.

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
mode  input  1  0 = 8-bit frame (data only), 1 = 10-bit frame (start + 8 data + stop)
push  input  1  one-cycle strobe: push_data holds a completed frame
push_data  input  10  frame bits, LSB first as received; bit0 = start, bits[8:1] = data, bit9 = stop in mode 1; bits[7:0] = data in mode 0
pop  input  1  read request from APB side
pop_data  output  8  data byte of the popped entry
pop_ferr  output  1  frame-error flag of the popped entry
pop_valid  output  1  one-cycle pulse: pop_data/pop_ferr updated this cycle
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  AW+1  current fill level, 0..DEPTH
overflow  output  1  sticky: a push was dropped
ovf_clr  input  1  clears overflow
thresh_irq  output  1  count >= THRESH

Behaviour:
- Reset (rstn low at clk edge): wptr = 0, rptr = 0, count = 0, empty = 1, full = 0, overflow = 0, pop_valid = 0, pop_data = 0, pop_ferr = 0, thresh_irq = 0. Storage contents are don't-care. Reset mid-operation discards all entries; any pop_valid due next cycle is suppressed.
- Entry format: 9 bits, {ferr, data[7:0]}.
  - mode 0: data = push_data[7:0], ferr = 0.
  - mode 1: data = push_data[8:1], ferr = push_data[0] | ~push_data[9] (start must be 0, stop must be 1).
  - mode is sampled on the push cycle.
- Write: push && (!full || pop_accept) -> entry written at wptr; wptr increments modulo DEPTH.
- Read: pop_accept = pop && !empty.
  - On pop_accept, the entry at rptr is registered into pop_data/pop_ferr and pop_valid = 1 on the next cycle (latency 1).
  - rptr increments modulo DEPTH.
  - pop_valid is 0 in every other cycle; pop_data/pop_ferr hold their last value.
- Pop while empty: ignored; no pointer change, no pop_valid, no error flag.
- Push while full without pop_accept: frame dropped, pointers unchanged, overflow = 1 next cycle.
- Push while full with pop_accept in the same cycle: both operations occur, count stays DEPTH, no overflow.
- Push while empty with pop in the same cycle: push accepted, pop ignored (no fall-through); count becomes 1.
- count next = count + (push accepted) - (pop_accept).
- empty, full and thresh_irq are registered, derived from next-count, so they are valid in the same cycle count updates (one cycle after the causing edge).
- overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr = 1 clears it next cycle.
- Pointer wrap: after DEPTH accepted pushes, wptr returns to 0; ordering is strictly FIFO across the wrap.

Test Plan:
- Reset then mode 0, push 0xA5, 0x3C -> count = 2, empty = 0; two pops -> pop_valid pulses with pop_data 0xA5 then 0x3C, pop_ferr = 0, count = 0, empty = 1.
- mode 1 push_data = 10'b1_01010101_0 -> pop gives 0x55, ferr = 0. Push 10'b0_11110000_0 (bad stop) -> ferr = 1. Push 10'b1_00000001_1 (bad start) -> data 0x01, ferr = 1.
- Push 16 frames (0x00..0x0F) -> full = 1, count = 16, thresh_irq = 1 from count 8. Push 0xFF -> dropped, overflow = 1. ovf_clr -> overflow = 0. Pop 16 -> 0x00..0x0F in order.
- Full FIFO with simultaneous push 0x77 and pop -> pops oldest, count stays 16, overflow stays 0, 0x77 is the last entry read.
- Empty FIFO: pop alone -> no pop_valid, count 0. Push 0x12 with pop same cycle -> count 1, no pop_valid.
- Wrap: 20 interleaved push/pop pairs with values 0..19 -> outputs 0..19 in order. rstn low mid-stream with 5 entries -> count = 0, empty = 1, overflow = 0 next cycle.

Source files
------------

// File: rtl/apb_rx_fifo.sv
// rtl/apb_rx_fifo.sv - UART RX receive FIFO with frame check, overflow and threshold status
module apb_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mode,
  input  logic          push,
  input  logic [9:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          pop_ferr,
  output logic          pop_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic          thresh_irq
);

  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW + 1)'(THRESH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  logic [7:0]    in_data;
  logic          in_ferr;
  logic          pop_accept;
  logic          push_accept;
  logic          push_drop;
  logic [AW:0]   count_nxt;

  // Start bit must be 0 and stop bit must be 1 in 10-bit frames.
  always_comb begin
    in_data = push_data[7:0];
    in_ferr = 1'b0;
    if (mode) begin
      in_data = push_data[8:1];
      in_ferr = push_data[0] | ~push_data[9];
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign pop_accept  = pop && !empty;
  assign push_accept = push && (!full || pop_accept);
  assign push_drop   = push && full && !pop_accept;

  always_comb begin
    count_nxt = count;
    if (push_accept && !pop_accept) begin
      count_nxt = count + (AW + 1)'(1);
    end else if (!push_accept && pop_accept) begin
      count_nxt = count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wptr] <= {in_ferr, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      thresh_irq <= 1'b0;
    end else begin
      if (push_accept) begin
        wptr <= wptr + AW'(1);
      end
      if (pop_accept) begin
        rptr <= rptr + AW'(1);
      end
      count      <= count_nxt;
      empty      <= (count_nxt == '0);
      full       <= (count_nxt == DEPTH_C);
      thresh_irq <= (count_nxt >= THRESH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pop_valid <= 1'b0;
      pop_data  <= '0;
      pop_ferr  <= 1'b0;
    end else begin
      pop_valid <= pop_accept;
      if (pop_accept) begin
        pop_data <= mem[rptr][7:0];
        pop_ferr <= mem[rptr][8];
      end
    end
  end

  // A dropped push wins over a simultaneous clear so the loss is never hidden.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (push_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule
